// File: rtl/prio_rr_arbiter.sv
// Request arbiter with fixed-priority or round-robin selection and a grant lock
// that holds the chosen requester until downstream accepts or the request drops.
module prio_rr_arbiter #(
  parameter int PORTS = 4,
  parameter int RR    = 1,
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PORTS-1:0] req_i,
  input  logic             ready_i,
  input  logic             flush_i,
  output logic [PORTS-1:0] grant_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] lidx_reg;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             lock_req;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             handshake;
  logic [IDX_W-1:0] ptr_next;
  int               cand;

  // Constant-index scan keeps the selection free of out-of-range bit picks.
  function automatic logic req_at(input logic [PORTS-1:0] v, input int pos);
    req_at = 1'b0;
    for (int j = 0; j < PORTS; j++) begin
      if (j == pos) req_at = v[j];
    end
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < PORTS; k++) begin
      cand = (RR != 0) ? ((int'(ptr_reg) + k) % PORTS) : k;
      if (!pick_found && req_at(req_i, cand)) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign lock_req = req_at(req_i, int'(lidx_reg));

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (!flush_i) begin
      if (state_reg == LOCKED) begin
        sel_valid = lock_req;
        sel_idx   = lock_req ? lidx_reg : '0;
      end else begin
        sel_valid = pick_found;
        sel_idx   = pick_idx;
      end
    end
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_grant
    assign grant_o[gi] = sel_valid && (sel_idx == IDX_W'(gi));
  end

  assign valid_o   = |grant_o;
  assign idx_o     = sel_idx;
  assign handshake = valid_o && ready_i;
  assign ptr_next  = (idx_o == IDX_W'(PORTS - 1)) ? '0 : idx_o + IDX_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      lidx_reg  <= '0;
    end else if (flush_i) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      lidx_reg  <= '0;
    end else begin
      if (handshake && (RR != 0)) ptr_reg <= ptr_next;
      case (state_reg)
        IDLE: begin
          if (valid_o && !ready_i) begin
            state_reg <= LOCKED;
            lidx_reg  <= idx_o;
          end
        end
        LOCKED: begin
          // Leave the lock on acceptance or when the holder withdraws.
          if (handshake || !lock_req) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench: round-robin, fixed-priority and 3-port instances of the arbiter.
module tb_prio_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;
  logic       flush;
  logic [3:0] grant;
  logic       valid;
  logic [1:0] idx;

  logic [3:0] req0;
  logic       ready0;
  logic       flush0;
  logic [3:0] grant0;
  logic       valid0;
  logic [1:0] idx0;

  logic [2:0] req3;
  logic       ready3;
  logic       flush3;
  logic [2:0] grant3;
  logic       valid3;
  logic [1:0] idx3;

  int checks = 0;
  int errors = 0;

  prio_rr_arbiter #(.PORTS(4), .RR(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ready_i(ready), .flush_i(flush),
    .grant_o(grant), .valid_o(valid), .idx_o(idx)
  );

  prio_rr_arbiter #(.PORTS(4), .RR(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .ready_i(ready0), .flush_i(flush0),
    .grant_o(grant0), .valid_o(valid0), .idx_o(idx0)
  );

  prio_rr_arbiter #(.PORTS(3), .RR(1)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .ready_i(ready3), .flush_i(flush3),
    .grant_o(grant3), .valid_o(valid3), .idx_o(idx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] eg, input logic [1:0] ei);
    #1;
    $display("txn %s req=%b ready=%b flush=%b grant=%b idx=%0d", tag, req, ready, flush, grant, idx);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".valid"}, 32'(valid), 32'(|eg));
    chk({tag, ".idx"},   32'(idx),   32'(ei));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; req = 4'b1111; ready = 1'b1; flush = 1'b0;
    req0 = 4'b0000; ready0 = 1'b0; flush0 = 1'b0;
    req3 = 3'b000; ready3 = 1'b0; flush3 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk4("in_reset", 4'b0001, 2'd0);
    rst_n = 1'b1;

    // Rotation from reset
    chk4("rot0", 4'b0001, 2'd0); nxt();
    chk4("rot1", 4'b0010, 2'd1); nxt();
    chk4("rot2", 4'b0100, 2'd2); nxt();
    chk4("rot3", 4'b1000, 2'd3); nxt();
    chk4("rot4", 4'b0001, 2'd0); nxt();

    // Flush in IDLE: no grant, pointer back to 0
    flush = 1'b1;
    chk4("flush_idle", 4'b0000, 2'd0); nxt();
    flush = 1'b0;

    // Lock on index 1, then a handshake moves the pointer to 2
    req = 4'b0110; ready = 1'b0;
    chk4("lock_take", 4'b0010, 2'd1); nxt();
    req = 4'b0111;
    chk4("lock_hold", 4'b0010, 2'd1); nxt();
    ready = 1'b1;
    chk4("lock_hs", 4'b0010, 2'd1); nxt();
    ready = 1'b0;
    chk4("after_hs", 4'b0100, 2'd2); nxt();

    // Locked on 2, holder drops
    req = 4'b0001; ready = 1'b1;
    chk4("drop", 4'b0000, 2'd0); nxt();
    ready = 1'b0;
    chk4("post_drop", 4'b0001, 2'd0); nxt();
    req = 4'b0100;
    chk4("drop2", 4'b0000, 2'd0); nxt();
    req = 4'b0101; ready = 1'b1;
    chk4("ptr_kept", 4'b0100, 2'd2); nxt();

    // Pointer now 3: wrap search, lock on 0, then flush while locked
    req = 4'b0011; ready = 1'b0;
    chk4("wrap", 4'b0001, 2'd0); nxt();
    flush = 1'b1;
    chk4("flush_lock", 4'b0000, 2'd0); nxt();
    flush = 1'b0; req = 4'b1010; ready = 1'b1;
    chk4("post_flush", 4'b0010, 2'd1); nxt();

    // No requests: outputs zero, pointer (2) preserved
    req = 4'b0000;
    chk4("idle_zero", 4'b0000, 2'd0); nxt();
    req = 4'b1111; ready = 1'b0;
    chk4("idle_ptr", 4'b0100, 2'd2); nxt();
    flush = 1'b1; nxt();
    flush = 1'b0; req = 4'b0000;

    // Fixed priority instance
    req0 = 4'b1111; ready0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("txn fixed%0d req=%b grant=%b idx=%0d", i, req0, grant0, idx0);
      chk("fixed.grant", 32'(grant0), 32'h1);
      chk("fixed.idx", 32'(idx0), 32'h0);
      nxt();
    end
    req0 = 4'b1100; #1;
    $display("txn fixed_hi req=%b grant=%b idx=%0d", req0, grant0, idx0);
    chk("fixed_hi.grant", 32'(grant0), 32'h4);
    chk("fixed_hi.idx", 32'(idx0), 32'h2);
    nxt();
    req0 = 4'b0110; ready0 = 1'b0; #1;
    $display("txn fixed_lock req=%b grant=%b idx=%0d", req0, grant0, idx0);
    chk("fixed_lock.grant", 32'(grant0), 32'h2);
    nxt();
    req0 = 4'b0011; #1;
    $display("txn fixed_hold req=%b grant=%b idx=%0d", req0, grant0, idx0);
    chk("fixed_hold.grant", 32'(grant0), 32'h2);
    chk("fixed_hold.valid", 32'(valid0), 32'h1);
    nxt();
    req0 = 4'b0000;

    // Three-port instance wraps 2 -> 0
    req3 = 3'b111; ready3 = 1'b1;
    begin
      logic [2:0] exp3 [4];
      exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100; exp3[3] = 3'b001;
      for (int i = 0; i < 4; i++) begin
        #1;
        $display("txn p3_%0d req=%b grant=%b idx=%0d", i, req3, grant3, idx3);
        chk("p3.grant", 32'(grant3), 32'(exp3[i]));
        chk("p3.valid", 32'(valid3), 32'h1);
        nxt();
      end
    end
    req3 = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_rr_arbiter.md
PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 The block SHALL have parameter PORTS, default 4: number of requesters, legal range 1..32.
REQ-002 The block SHALL have parameter RR, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 The block SHALL have derived localparam IDX_W, default 2: max(1, $clog2(PORTS)).
REQ-004 The block SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port req_i  input  PORTS  per-requester request, level.
REQ-007 The block SHALL have port ready_i  input  1  downstream accepts the granted transfer this cycle.
REQ-008 The block SHALL have port flush_i  input  1  synchronous clear of lock and pointer.
REQ-009 The block SHALL have port grant_o  output  PORTS  one-hot or zero grant.
REQ-010 The block SHALL have port valid_o  output  1  equals |grant_o.
REQ-011 The block SHALL have port idx_o  output  IDX_W  binary index of the granted port; 0 when valid_o=0.

Function
REQ-012 The block SHALL hold state {IDLE, LOCKED}, a pointer ptr (IDX_W bits) and a locked index lidx (IDX_W bits).
REQ-013 In IDLE, grant SHALL be combinational from req_i in the same cycle (zero latency).
- RR=0: lowest set index wins.
- RR=1: search ptr, ptr+1, ..., PORTS-1, 0, ..., ptr-1; first set index wins.
REQ-014 The block SHALL assert at most one bit of grant_o in any cycle.
REQ-015 Handshake SHALL be valid_o && ready_i.
- On handshake with RR=1: ptr <= (idx_o+1) mod PORTS, wrapping PORTS-1 -> 0.
- With RR=0: ptr stays 0.
REQ-016 IDLE with valid_o=1 and ready_i=0 SHALL go to LOCKED next cycle with lidx <= idx_o.
REQ-017 In LOCKED, grant_o SHALL be onehot(lidx) if req_i[lidx]=1, regardless of other requests and of RR, else 0.
REQ-018 LOCKED with handshake SHALL update ptr per REQ-015 and return to IDLE next cycle.
REQ-019 LOCKED with req_i[lidx]=0 SHALL:
- give grant_o=0 that cycle;
- return to IDLE next cycle;
- leave ptr unchanged.
REQ-020 LOCKED with req_i[lidx]=1 and ready_i=0 SHALL stay LOCKED, lidx unchanged.
REQ-021 flush_i=1 SHALL take priority over all other events:
- grant_o=0 and valid_o=0 that cycle;
- next state IDLE, ptr <= 0, lidx <= 0;
- no handshake counted.
REQ-022 With req_i=0 in IDLE, outputs SHALL be all zero and state/ptr SHALL be unchanged.
REQ-023 With PORTS=1, idx_o SHALL be constant 0 and ptr SHALL remain 0.
REQ-024 A non-power-of-2 PORTS SHALL never let ptr or lidx reach a value >= PORTS.

Reset
REQ-025 While rst_ni=0, asynchronously: state=IDLE, ptr=0, lidx=0.
REQ-026 Outputs SHALL follow REQ-013 from the reset state, so the first grant after reset is from index 0 upward.
REQ-027 Reset asserted while LOCKED SHALL abandon the lock with no pointer update.

Verification (PORTS=4, RR=1 unless stated)
REQ-028 Reset with req_i=4'b1111 held, ready_i=1, then release -> first cycle grant_o=0001, idx_o=0.
REQ-029 Rotation: req_i=1111, ready_i=1 for 5 cycles -> grant_o sequence 0001, 0010, 0100, 1000, 0001.
REQ-030 Lock:
- ptr=0, req_i=0110, ready_i=0 -> grant_o=0010;
- next cycle req_i=0111, ready_i=0 -> grant_o still 0010;
- then ready_i=1 -> handshake; next cycle with req_i=0111 -> grant_o=0100 (ptr=2).
REQ-031 Drop while locked:
- locked on lidx=2, req_i=0001 -> grant_o=0000 that cycle;
- next cycle grant_o=0001;
- ptr unchanged until that handshake.
REQ-032 Wrap and flush:
- ptr=3, req_i=0011 -> grant_o=0001;
- flush_i=1 while LOCKED -> grant_o=0000; next cycle ptr=0, state IDLE.
REQ-033 RR=0: req_i=1111, ready_i=1 every cycle -> grant_o=0001 every cycle; req_i=1100 -> 0100.
